// File: rtl/timer_pkg.sv
// Shared encodings for the countdown timer: FSM states, BCD digit limits,
// and the debug view exported by cnt60_down.
package timer_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    ALARM = 2'd3
  } state_e;

  localparam logic [3:0] BCD_MAX_ONES = 4'd9;
  localparam logic [3:0] BCD_MAX_TENS = 4'd5;

  // wrap flags a manual step from 00:00 to 59:59 in the current cycle
  typedef struct packed {
    state_e state;
    logic   wrap;
  } dbg_t;

endpackage

// File: rtl/bcd_dn_digit.sv
// One BCD down-counting digit wrapping 0 -> MAXV, with saturating preset load.
// borrow is asserted when a decrement wraps this digit, feeding the next digit.
module bcd_dn_digit
  import timer_pkg::*;
#(
  parameter logic [3:0] MAXV = BCD_MAX_ONES
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       en,
  input  logic       load,
  input  logic [3:0] ld_val,
  output logic [3:0] q,
  output logic       borrow
);

  logic [3:0] q_q;
  logic [3:0] q_d;

  always_comb begin
    q_d = q_q;
    if (load) begin
      q_d = (ld_val > MAXV) ? MAXV : ld_val;
    end else if (en) begin
      q_d = (q_q == 4'd0) ? MAXV : q_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      q_q <= 4'd0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q      = q_q;
  assign borrow = en && (q_q == 4'd0);

endmodule

// File: rtl/cnt60_down.sv
// BCD MM:SS countdown timer with IDLE/RUN/PAUSE/ALARM control FSM.
// Optional alarm auto-timeout is enabled by defining CNT60_DOWN_ALARM_TO_EN.
module cnt60_down
  import timer_pkg::*;
#(
  parameter int unsigned ALARM_TICKS = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       enin,
  input  logic       dec,
  input  logic       load,
  input  logic [3:0] ld_sec_l,
  input  logic [3:0] ld_sec_h,
  input  logic [3:0] ld_min_l,
  input  logic [3:0] ld_min_h,
  input  logic       start,
  input  logic       stop,
  output logic [3:0] sec_l,
  output logic [3:0] sec_h,
  output logic [3:0] min_l,
  output logic [3:0] min_h,
  output logic       running,
  output logic       alarm,
  output logic       zero,
  output dbg_t       dbg
);

  state_e state_q;
  state_e state_d;
  logic   step;
  logic   is_one;
  logic   b_sl, b_sh, b_ml, b_mh;

  bcd_dn_digit #(.MAXV(BCD_MAX_ONES)) u_sec_l (
    .clk(clk), .rst(rst), .clr(clr), .en(step), .load(load),
    .ld_val(ld_sec_l), .q(sec_l), .borrow(b_sl)
  );
  bcd_dn_digit #(.MAXV(BCD_MAX_TENS)) u_sec_h (
    .clk(clk), .rst(rst), .clr(clr), .en(b_sl), .load(load),
    .ld_val(ld_sec_h), .q(sec_h), .borrow(b_sh)
  );
  bcd_dn_digit #(.MAXV(BCD_MAX_ONES)) u_min_l (
    .clk(clk), .rst(rst), .clr(clr), .en(b_sh), .load(load),
    .ld_val(ld_min_l), .q(min_l), .borrow(b_ml)
  );
  bcd_dn_digit #(.MAXV(BCD_MAX_TENS)) u_min_h (
    .clk(clk), .rst(rst), .clr(clr), .en(b_ml), .load(load),
    .ld_val(ld_min_h), .q(min_h), .borrow(b_mh)
  );

  assign zero   = (sec_l == 4'd0) && (sec_h == 4'd0) && (min_l == 4'd0) && (min_h == 4'd0);
  // Current value 00:01 means the next tick lands on 00:00.
  assign is_one = (sec_l == 4'd1) && (sec_h == 4'd0) && (min_l == 4'd0) && (min_h == 4'd0);

`ifdef CNT60_DOWN_ALARM_TO_EN
  localparam int unsigned TW = $clog2(ALARM_TICKS + 1);
  logic [TW-1:0] to_cnt_q;
  logic          to_done;

  assign to_done = enin && (to_cnt_q == TW'(ALARM_TICKS - 1));

  // Held at zero outside ALARM, so it is clean on every entry.
  always_ff @(posedge clk) begin
    if (rst || clr || (state_q != ALARM)) begin
      to_cnt_q <= '0;
    end else if (enin) begin
      to_cnt_q <= to_cnt_q + TW'(1);
    end
  end
`else
  logic to_done;
  assign to_done = 1'b0;
`endif

  // Priority below rst/clr: load > stop > start > enin/dec.
  always_comb begin
    state_d = state_q;
    step    = 1'b0;
    if (load) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE, PAUSE: begin
          if (!stop && start) begin
            if (!zero) state_d = RUN;
          end else if (!stop) begin
            step = dec;
          end
        end
        RUN: begin
          if (stop) begin
            state_d = PAUSE;
          end else if (!start && enin) begin
            step = 1'b1;
            if (is_one) state_d = ALARM;
          end
        end
        ALARM: begin
          if (stop || start || to_done) state_d = IDLE;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  assign running   = (state_q == RUN);
  assign alarm     = (state_q == ALARM);
  assign dbg.state = state_q;
  assign dbg.wrap  = b_mh;

endmodule

// File: tb/tb_cnt60_down.sv
// Bench for cnt60_down: directed scenarios plus a random phase, all checked
// against a seconds-count reference model after every clock edge.
module tb_cnt60_down;
  import timer_pkg::*;

  localparam int ALARM_TICKS = 10;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, clr, enin, dec, load, start, stop;
  logic [3:0] ld_sec_l, ld_sec_h, ld_min_l, ld_min_h;
  logic [3:0] sec_l, sec_h, min_l, min_h;
  logic       running, alarm, zero;
  dbg_t       dbg;

  cnt60_down #(.ALARM_TICKS(ALARM_TICKS)) dut (
    .clk(clk), .rst(rst), .clr(clr), .enin(enin), .dec(dec), .load(load),
    .ld_sec_l(ld_sec_l), .ld_sec_h(ld_sec_h), .ld_min_l(ld_min_l), .ld_min_h(ld_min_h),
    .start(start), .stop(stop),
    .sec_l(sec_l), .sec_h(sec_h), .min_l(min_l), .min_h(min_h),
    .running(running), .alarm(alarm), .zero(zero), .dbg(dbg)
  );

  // reference model: remaining time in seconds plus a mode number
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_ALARM = 3;
  int m_total = 0;
  int m_mode  = M_IDLE;
  int m_to    = 0;

  // scoreboard
  logic [18:0] exp_q[$];
  int          exp_mode_q[$];
  int          chk_cnt  = 0;
  int          pass_cnt = 0;

  function automatic int sat(input logic [3:0] v, input int maxv);
    return (int'(v) > maxv) ? maxv : int'(v);
  endfunction

  task automatic idle_inputs();
    rst = 1'b0; clr = 1'b0; enin = 1'b0; dec = 1'b0;
    load = 1'b0; start = 1'b0; stop = 1'b0;
  endtask

  task automatic set_ld(input int mh, input int ml, input int sh, input int sl);
    ld_min_h = 4'(mh); ld_min_l = 4'(ml); ld_sec_h = 4'(sh); ld_sec_l = 4'(sl);
  endtask

  task automatic model_edge();
    int m, s;
    if (rst || clr) begin
      m_total = 0;
      m_mode  = M_IDLE;
    end else if (load) begin
      m_total = (sat(ld_min_h, 5) * 10 + sat(ld_min_l, 9)) * 60
              + sat(ld_sec_h, 5) * 10 + sat(ld_sec_l, 9);
      m_mode  = M_IDLE;
    end else if (stop) begin
      if (m_mode == M_RUN) m_mode = M_PAUSE;
      else if (m_mode == M_ALARM) m_mode = M_IDLE;
    end else if (start) begin
      if ((m_mode == M_IDLE || m_mode == M_PAUSE) && m_total != 0) m_mode = M_RUN;
      else if (m_mode == M_ALARM) m_mode = M_IDLE;
    end else if (m_mode == M_RUN && enin) begin
      m_total = m_total - 1;
      if (m_total == 0) begin
        m_mode = M_ALARM;
        m_to   = 0;
      end
    end else if ((m_mode == M_IDLE || m_mode == M_PAUSE) && dec) begin
      m_total = (m_total + 3599) % 3600;
    end else if (m_mode == M_ALARM && enin) begin
`ifdef CNT60_DOWN_ALARM_TO_EN
      m_to = m_to + 1;
      if (m_to == ALARM_TICKS) m_mode = M_IDLE;
`endif
    end
    m = m_total / 60;
    s = m_total % 60;
    exp_q.push_back({4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10),
                     m_mode == M_RUN, m_mode == M_ALARM, m_total == 0});
    exp_mode_q.push_back(m_mode);
  endtask

  task automatic check(input string tag);
    logic [18:0] exp_v, got_v;
    logic [1:0]  exp_st;
    exp_v  = exp_q.pop_front();
    exp_st = 2'(exp_mode_q.pop_front());
    got_v  = {min_h, min_l, sec_h, sec_l, running, alarm, zero};
    chk_cnt++;
    assert (got_v === exp_v) pass_cnt++;
    else $error("FAIL %s observed=%h expected=%h (mmss/run/alarm/zero)", tag, got_v, exp_v);
    chk_cnt++;
    assert (dbg.state === exp_st) pass_cnt++;
    else $error("FAIL %s_state observed=%0d expected=%0d", tag, dbg.state, exp_st);
  endtask

  // driver: inputs already set; apply one edge, check, release pulses
  task automatic cycle(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
    idle_inputs();
  endtask

  task automatic gap();
    repeat ($urandom_range(0, 2)) cycle("gap");
  endtask

  initial begin
    idle_inputs();
    set_ld(0, 0, 0, 0);
    #2;

    // reset
    rst = 1'b1; cycle("reset");
    rst = 1'b1; cycle("reset2");

    // 01:02 countdown to alarm
    set_ld(0, 1, 0, 2); load = 1'b1; cycle("load_0102");
    start = 1'b1; cycle("start");
    for (int i = 0; i < 62; i++) begin
      enin = 1'b1; cycle("tick");
      gap();
    end
    enin = 1'b1; cycle("alarm_ignores_enin");
    stop = 1'b1; cycle("stop_ack");

    // multi-digit borrow
    set_ld(1, 0, 0, 0); load = 1'b1; cycle("load_1000");
    start = 1'b1; cycle("start_1000");
    enin = 1'b1; cycle("tick_0959");

    // manual wrap and start at zero
    clr = 1'b1; cycle("clr");
    dec = 1'b1; cycle("dec_wrap");
    dec = 1'b1; enin = 1'b1; cycle("dec_enin_one_step");
    clr = 1'b1; cycle("clr2");
    start = 1'b1; cycle("start_at_zero");

    // start & stop together, then paused ticks
    set_ld(0, 0, 3, 0); load = 1'b1; cycle("load_0030");
    start = 1'b1; cycle("start_0030");
    start = 1'b1; stop = 1'b1; cycle("start_stop");
    for (int i = 0; i < 3; i++) begin
      enin = 1'b1; cycle("pause_tick");
    end
    dec = 1'b1; cycle("pause_dec");
    load = 1'b1; start = 1'b1; cycle("load_start");

    // saturating load
    set_ld(0, 0, 7, 12); load = 1'b1; cycle("sat_sec");
    set_ld(14, 15, 6, 10); load = 1'b1; cycle("sat_all");

    // clr during alarm
    set_ld(0, 0, 0, 2); load = 1'b1; cycle("load_0002");
    start = 1'b1; cycle("start_0002");
    enin = 1'b1; cycle("tick1");
    enin = 1'b1; cycle("tick_alarm");
    clr = 1'b1; cycle("clr_alarm");

    // alarm duration over 20 ticks
    set_ld(0, 0, 0, 1); load = 1'b1; cycle("load_0001");
    start = 1'b1; cycle("start_0001");
    enin = 1'b1; cycle("tick_alarm2");
    for (int i = 0; i < 20; i++) begin
      enin = 1'b1; cycle("alarm_hold");
      gap();
    end
    load = 1'b1; cycle("load_in_alarm_or_idle");

    // random phase
    for (int i = 0; i < 600; i++) begin
      clr   = ($urandom_range(0, 99) < 2);
      load  = ($urandom_range(0, 99) < 5);
      stop  = ($urandom_range(0, 99) < 5);
      start = ($urandom_range(0, 99) < 12);
      enin  = ($urandom_range(0, 99) < 40);
      dec   = ($urandom_range(0, 99) < 15);
      if ($urandom_range(0, 1) == 1) begin
        set_ld(0, 0, $urandom_range(0, 1), $urandom_range(0, 15));
      end else begin
        set_ld($urandom_range(0, 15), $urandom_range(0, 15),
               $urandom_range(0, 15), $urandom_range(0, 15));
      end
      cycle("random");
    end

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
